// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache refill path and
// the D-cache refill/writeback path. One line transfer is outstanding at a time:
// an address phase, then BEATS write beats (D writeback) or BEATS read beats.
// D has fixed priority; after STARVE_LIMIT D grants taken while I was waiting,
// I is forced to win the next arbitration.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ic_req_*              I-side line read request (valid/ready/addr)
//   ic_resp_*             I-side read beats (valid/data/last), registered
//   dc_req_*              D-side request (valid/ready/rw/addr)
//   dc_wdata*             D-side write beats, passed straight through to memory
//   dc_resp_*             D-side read beats or write-complete pulse, registered
//   mem_req_*             memory address phase (valid/ready/rw/addr)
//   mem_wdata*            memory write beats
//   mem_resp_*            memory read beats, no backpressure
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned BEATS        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // I-cache side
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,
    output logic                  ic_resp_last,
    // D-cache side
    input  logic                  dc_req_valid,
    input  logic                  dc_req_rw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_ready,
    input  logic                  dc_wdata_valid,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_wdata_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,
    output logic                  dc_resp_last,
    // Memory side
    output logic                  mem_req_valid,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    output logic                  mem_wdata_valid,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wdata_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int unsigned BeatW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BeatW-1:0]   LastBeat  = BeatW'(BEATS - 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRdata} state_e;

    state_e                state_q, state_d;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic [StarveW-1:0]    starve_q, starve_d;
    logic                  own_dc_q, own_dc_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  ic_valid_q, ic_valid_d;
    logic                  ic_last_q, ic_last_d;
    logic [DATA_WIDTH-1:0] ic_data_q, ic_data_d;
    logic                  dc_valid_q, dc_valid_d;
    logic                  dc_last_q, dc_last_d;
    logic [DATA_WIDTH-1:0] dc_data_q, dc_data_d;

    logic grant_ic;
    logic grant_dc;
    logic beat_last;

    // I only overrides D once it has been passed over STARVE_LIMIT times.
    assign grant_ic  = ic_req_valid && (!dc_req_valid || (starve_q == StarveMax));
    assign grant_dc  = dc_req_valid && !grant_ic;
    assign beat_last = (beat_q == LastBeat);

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        starve_d        = starve_q;
        own_dc_d        = own_dc_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        ic_valid_d      = 1'b0;
        ic_last_d       = 1'b0;
        ic_data_d       = '0;
        dc_valid_d      = 1'b0;
        dc_last_d       = 1'b0;
        dc_data_d       = '0;
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        dc_wdata_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gate with reset so no ready escapes while the block is held in reset.
                ic_req_ready = grant_ic && reset;
                dc_req_ready = grant_dc && reset;
                if (grant_ic) begin
                    own_dc_d = 1'b0;
                    rw_d     = 1'b0;
                    addr_d   = ic_req_addr;
                    starve_d = '0;
                    state_d  = StAddr;
                end else if (grant_dc) begin
                    own_dc_d = 1'b1;
                    rw_d     = dc_req_rw;
                    addr_d   = dc_req_addr;
                    if (ic_req_valid && (starve_q != StarveMax)) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = StAddr;
                end
            end
            StAddr: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = rw_q ? StWdata : StRdata;
                end
            end
            StWdata: begin
                mem_wdata_valid = dc_wdata_valid;
                mem_wdata       = dc_wdata;
                dc_wdata_ready  = mem_wdata_ready;
                if (dc_wdata_valid && mem_wdata_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        // Write-complete pulse; response data stays zero.
                        dc_valid_d = 1'b1;
                        dc_last_d  = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StRdata: begin
                if (mem_resp_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (own_dc_q) begin
                        dc_valid_d = 1'b1;
                        dc_data_d  = mem_resp_data;
                        dc_last_d  = beat_last;
                    end else begin
                        ic_valid_d = 1'b1;
                        ic_data_d  = mem_resp_data;
                        ic_last_d  = beat_last;
                    end
                    if (beat_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            starve_q   <= '0;
            own_dc_q   <= 1'b1;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            ic_valid_q <= 1'b0;
            ic_last_q  <= 1'b0;
            ic_data_q  <= '0;
            dc_valid_q <= 1'b0;
            dc_last_q  <= 1'b0;
            dc_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            starve_q   <= starve_d;
            own_dc_q   <= own_dc_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            ic_valid_q <= ic_valid_d;
            ic_last_q  <= ic_last_d;
            ic_data_q  <= ic_data_d;
            dc_valid_q <= dc_valid_d;
            dc_last_q  <= dc_last_d;
            dc_data_q  <= dc_data_d;
        end
    end

    assign ic_resp_valid = ic_valid_q;
    assign ic_resp_data  = ic_data_q;
    assign ic_resp_last  = ic_last_q;
    assign dc_resp_valid = dc_valid_q;
    assign dc_resp_data  = dc_data_q;
    assign dc_resp_last  = dc_last_q;
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_last;
    logic [31:0]  ic_req_addr;
    logic [127:0] ic_resp_data;
    logic         dc_req_valid, dc_req_rw, dc_req_ready;
    logic [31:0]  dc_req_addr;
    logic         dc_wdata_valid, dc_wdata_ready, dc_resp_valid, dc_resp_last;
    logic [127:0] dc_wdata, dc_resp_data;
    logic         mem_req_valid, mem_req_rw, mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
    logic [127:0] mem_wdata, mem_resp_data;

    int total = 0;
    int bad   = 0;

    bit wv_pat [12] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    bit wr_pat [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_req_ready    (ic_req_ready),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_data    (ic_resp_data),
        .ic_resp_last    (ic_resp_last),
        .dc_req_valid    (dc_req_valid),
        .dc_req_rw       (dc_req_rw),
        .dc_req_addr     (dc_req_addr),
        .dc_req_ready    (dc_req_ready),
        .dc_wdata_valid  (dc_wdata_valid),
        .dc_wdata        (dc_wdata),
        .dc_wdata_ready  (dc_wdata_ready),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_data    (dc_resp_data),
        .dc_resp_last    (dc_resp_last),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata       (mem_wdata),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
    );

    wire any_out = |{ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
                     dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
                     mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a single request at a negedge, check arbitration, drop it after the edge.
    task automatic accept(input bit is_dc, input logic rw, input logic [31:0] addr);
        @(negedge clk);
        if (is_dc) begin
            dc_req_valid = 1'b1;
            dc_req_rw    = rw;
            dc_req_addr  = addr;
        end else begin
            ic_req_valid = 1'b1;
            ic_req_addr  = addr;
        end
        #1;
        check("acc_dc_ready", dc_req_ready, is_dc);
        check("acc_ic_ready", ic_req_ready, !is_dc);
        @(posedge clk);
        #1;
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b0;
    endtask

    // Hold the address phase for 'waits' cycles before memory accepts it.
    task automatic addr_phase(input logic [31:0] addr, input logic rw, input int waits);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            mem_req_ready = (k == waits);
            #1;
            check("addr_valid", mem_req_valid, 1'b1);
            check("addr_addr", mem_req_addr, addr);
            check("addr_rw", mem_req_rw, rw);
            check("addr_no_ic_resp", ic_resp_valid, 1'b0);
            check("addr_no_dc_resp", dc_resp_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
    endtask

    // Four back-to-back memory beats; each must appear at the owner one cycle later.
    task automatic read_beats(input bit to_dc, input logic [127:0] base);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            mem_resp_valid = (i < 4);
            mem_resp_data  = (i < 4) ? base + 128'(i) : '0;
            #1;
            if (i > 0) begin
                check("rd_own_valid", to_dc ? dc_resp_valid : ic_resp_valid, 1'b1);
                check("rd_own_data", to_dc ? dc_resp_data : ic_resp_data, base + 128'(i - 1));
                check("rd_own_last", to_dc ? dc_resp_last : ic_resp_last, i == 4);
                check("rd_other_valid", to_dc ? ic_resp_valid : dc_resp_valid, 1'b0);
            end
        end
    endtask

    task automatic quiet_check(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_ic"}, ic_resp_valid, 1'b0);
        check({tag, "_dc"}, dc_resp_valid, 1'b0);
    endtask

    initial begin
        int  n;
        bit  found;
        bit  exp_dc;

        reset           = 1'b0;
        ic_req_valid    = 1'b1;
        ic_req_addr     = 32'h0;
        dc_req_valid    = 1'b1;
        dc_req_rw       = 1'b0;
        dc_req_addr     = 32'h0;
        dc_wdata_valid  = 1'b0;
        dc_wdata        = '0;
        mem_req_ready   = 1'b0;
        mem_wdata_ready = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_data   = '0;

        // Reset: everything quiet even with both requesters asserting.
        #12;
        check("reset_outputs", any_out, 1'b0);
        @(negedge clk);
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        reset        = 1'b1;

        // I-only read, address accepted after two wait cycles.
        accept(1'b0, 1'b0, 32'h1000);
        addr_phase(32'h1000, 1'b0, 2);
        read_beats(1'b0, 128'hA);
        quiet_check("i_read_end");

        // Simultaneous requests: D first, then I after D's last beat.
        @(negedge clk);
        dc_req_valid = 1'b1;
        dc_req_rw    = 1'b0;
        dc_req_addr  = 32'h2000;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h3000;
        #1;
        check("sim_dc_ready", dc_req_ready, 1'b1);
        check("sim_ic_ready", ic_req_ready, 1'b0);
        @(posedge clk);
        #1;
        dc_req_valid = 1'b0;
        addr_phase(32'h2000, 1'b0, 0);
        read_beats(1'b1, 128'h20);
        check("sim_turn_ic_ready", ic_req_ready, 1'b1);
        @(posedge clk);
        #1;
        ic_req_valid = 1'b0;
        addr_phase(32'h3000, 1'b0, 0);
        read_beats(1'b0, 128'h30);
        quiet_check("sim_end");

        // D write with gapped valid and toggling memory ready.
        accept(1'b1, 1'b1, 32'h4000);
        addr_phase(32'h4000, 1'b1, 1);
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            @(negedge clk);
            dc_wdata_valid  = wv_pat[c];
            mem_wdata_ready = wr_pat[c];
            dc_wdata        = 128'h40 + 128'(n);
            #1;
            check("wr_mem_valid", mem_wdata_valid, wv_pat[c]);
            check("wr_dc_ready", dc_wdata_ready, wr_pat[c]);
            check("wr_no_early_resp", dc_resp_valid, 1'b0);
            if (wv_pat[c] && wr_pat[c]) begin
                check("wr_beat_data", mem_wdata, 128'h40 + 128'(n));
                n++;
            end
        end
        check("wr_beat_count", n, 4);
        @(negedge clk);
        dc_wdata_valid  = 1'b1;
        mem_wdata_ready = 1'b1;
        #1;
        check("wr_done_valid", dc_resp_valid, 1'b1);
        check("wr_done_last", dc_resp_last, 1'b1);
        check("wr_done_data", dc_resp_data, 128'h0);
        check("wr_no_ic", ic_resp_valid, 1'b0);
        check("wr_idle_dc_ready", dc_wdata_ready, 1'b0);
        check("wr_idle_mem_valid", mem_wdata_valid, 1'b0);
        @(negedge clk);
        dc_wdata_valid  = 1'b0;
        mem_wdata_ready = 1'b0;
        #1;
        check("wr_pulse_once", dc_resp_valid, 1'b0);

        // Starvation: both held high -> D x4, I, then D again.
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h7000;
        dc_req_valid  = 1'b1;
        dc_req_rw     = 1'b0;
        dc_req_addr   = 32'h8000;
        mem_req_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_dc = (t != 4);
            found  = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                mem_resp_valid = 1'b0;
                #1;
                if (mem_req_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            check("st_grant_seen", found, 1'b1);
            check("st_grant_addr", mem_req_addr, exp_dc ? 32'h8000 : 32'h7000);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                mem_resp_valid = 1'b1;
                mem_resp_data  = 128'(t * 16 + b);
                #1;
                if (b == 1) begin
                    check("st_route", exp_dc ? dc_resp_valid : ic_resp_valid, 1'b1);
                end
            end
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        ic_req_valid   = 1'b0;
        dc_req_valid   = 1'b0;
        mem_req_ready  = 1'b0;
        quiet_check("st_end");

        // Stray memory beats in IDLE and ADDR are ignored; beat count is unaffected.
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'hBAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("stray_idle_ic", ic_resp_valid, 1'b0);
            check("stray_idle_dc", dc_resp_valid, 1'b0);
        end
        accept(1'b1, 1'b0, 32'h9000);
        addr_phase(32'h9000, 1'b0, 2);
        read_beats(1'b1, 128'h90);
        quiet_check("stray_end");

        // Reset during beat 2 of an I read, then a fresh D read with a stale beat present.
        accept(1'b0, 1'b0, 32'h5000);
        addr_phase(32'h5000, 1'b0, 0);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h51;
        @(negedge clk);
        mem_resp_data  = 128'h52;
        @(negedge clk);
        mem_resp_data  = 128'h53;
        #1;
        check("rst_pre_valid", ic_resp_valid, 1'b1);
        check("rst_pre_data", ic_resp_data, 128'h52);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_outputs", any_out, 1'b0);
        @(negedge clk);
        #1;
        check("rst_hold_outputs", any_out, 1'b0);
        reset = 1'b1;
        accept(1'b1, 1'b0, 32'h6000);
        addr_phase(32'h6000, 1'b0, 1);
        read_beats(1'b1, 128'h60);
        quiet_check("rst_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
